carry_scan_display: RTL

- Downstream consumer of the 4-bit loadable counter stage.
- Takes the counter's live digit `q` and its carry flag `co` and counts carry events into three further hex digits, forming a 16-bit value.
- Time-multiplexes the four digits onto a common-anode seven-segment display with optional leading-zero blanking.
- Sits between the counter and the board's display pins.

---
 rtl/disp_pkg.sv | 27 ++
 rtl/carry_scan_display_if.sv | 26 ++
 rtl/hex7seg.sv | 34 +++
 rtl/carry_scan_display.sv | 136 +++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display constants: active-low seven-segment glyphs ({g,f,e,d,c,b,a}),
// blank patterns and the width of one hex digit.
package disp_pkg;

  localparam int DIG_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/carry_scan_display_if.sv
// Bundle of the counter-side inputs and display-side outputs of the
// carry_scan_display block. The master side drives the counter digit, the
// carry flag and the controls; the slave side (the display block) drives
// the anode enables, segments and overflow flag.
interface carry_scan_display_if;
  import disp_pkg::*;

  logic [DIG_W-1:0] q;
  logic             co;
  logic             clr;
  logic             blank_lz;
  logic [3:0]       an;
  logic [6:0]       seg;
  logic             ovf;

  modport master (
    output q, co, clr, blank_lz,
    input  an, seg, ovf
  );

  modport slave (
    input  q, co, clr, blank_lz,
    output an, seg, ovf
  );

endinterface

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder, active-low outputs in
// {g,f,e,d,c,b,a} order, with lowercase b and d glyphs.
module hex7seg
  import disp_pkg::*;
(
  input  logic [DIG_W-1:0] digit_i,
  output logic [6:0]       seg_o
);

  // Look up the glyph for the incoming nibble.
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/carry_scan_display.sv
// Counts rising edges of the upstream counter's carry flag into three upper
// hex digits and scans those digits plus the live counter digit onto a
// common-anode seven-segment display, with optional leading-zero blanking.
module carry_scan_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 mr,
  carry_scan_display_if.slave  bus
);

  localparam int                PRE_W   = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  logic             coDly_q;
  logic [11:0]      upper_q;
  logic             ovf_q;
  logic [PRE_W-1:0] pre_q;
  logic [1:0]       sel_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;

  logic             inc;
  logic             tick;
  logic [1:0]       selNext;
  logic [DIG_W-1:0] digitNext;
  logic             blankNext;
  logic [6:0]       glyphNext;
  logic [3:0]       anNext;
  logic [6:0]       segNext;

  // Carry edge, scan tick and the slot that the next tick will show.
  always_comb begin
    inc     = bus.co & ~coDly_q;
    tick    = (pre_q == PRE_MAX);
    selNext = sel_q + 2'd1;
  end

  // Pick the digit for the upcoming slot; an upper digit is a leading zero
  // when it and every digit above it are zero. Digit 0 always shows.
  always_comb begin
    digitNext = bus.q;
    blankNext = 1'b0;
    case (selNext)
      2'd0: begin
        digitNext = bus.q;
      end
      2'd1: begin
        digitNext = upper_q[3:0];
        blankNext = bus.blank_lz && (upper_q == 12'h000);
      end
      2'd2: begin
        digitNext = upper_q[7:4];
        blankNext = bus.blank_lz && (upper_q[11:4] == 8'h00);
      end
      2'd3: begin
        digitNext = upper_q[11:8];
        blankNext = bus.blank_lz && (upper_q[11:8] == 4'h0);
      end
      default: begin
        digitNext = bus.q;
        blankNext = 1'b0;
      end
    endcase
  end

  hex7seg uDecode (
    .digit_i (digitNext),
    .seg_o   (glyphNext)
  );

  // Anode and segment values to load together on the next tick.
  always_comb begin
    anNext  = AN_OFF;
    segNext = SEG_BLANK;
    if (!blankNext) begin
      anNext  = ~(4'b0001 << selNext);
      segNext = glyphNext;
    end
  end

  // Carry edge register and the 12-bit upper counter; clear beats an
  // increment that lands in the same cycle, and the overflow flag is sticky
  // until cleared.
  always_ff @(posedge clk) begin
    if (mr) begin
      coDly_q <= 1'b0;
      upper_q <= 12'h000;
      ovf_q   <= 1'b0;
    end else begin
      coDly_q <= bus.co;
      if (bus.clr) begin
        upper_q <= 12'h000;
        ovf_q   <= 1'b0;
      end else if (inc) begin
        upper_q <= upper_q + 12'd1;
        if (upper_q == 12'hFFF) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // Prescaler and slot selector; starting the selector at 3 makes the first
  // tick after reset land on digit 0.
  always_ff @(posedge clk) begin
    if (mr) begin
      pre_q <= '0;
      sel_q <= 2'd3;
    end else if (tick) begin
      pre_q <= '0;
      sel_q <= selNext;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // Display registers load together on a tick so anode and segment never
  // disagree, and hold in between.
  always_ff @(posedge clk) begin
    if (mr) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else if (tick) begin
      an_q  <= anNext;
      seg_q <= segNext;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.ovf = ovf_q;

endmodule
